// File: rtl/stream_to_fifo_packer.sv
// Packs `ratio` narrow valid/ready beats into one wide word and pushes it into a FIFO.
// One completed word is held, so input beats keep flowing while the FIFO is briefly full.
module stream_to_fifo_packer #(
    parameter int in_width                      = 8,
    parameter int ratio                         = 4,
    parameter bit allow_push_when_full_with_pop = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [in_width-1:0]       in_data,
    input  logic                      in_last,
    input  logic                      full,
    input  logic                      pop,
    output logic                      push,
    output logic [in_width*ratio-1:0] write_data
);

    localparam int IDX_W = (ratio > 1) ? $clog2(ratio) : 1;
    localparam int ACC_N = (ratio > 1) ? ratio - 1 : 1;
    localparam int OUT_W = in_width * ratio;
    localparam bit MULTI = (ratio > 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ratio - 1);

    logic [ACC_N-1:0][in_width-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [OUT_W-1:0]               write_data_q, write_data_d;
    logic                           out_valid_q, out_valid_d;

    logic             closes;
    logic             accept;
    logic             complete;
    logic [OUT_W-1:0] word;

    // A beat "closes" the word when it lands in the top slice or flushes early.
    always_comb begin
        closes   = (idx_q == LAST_IDX) | (MULTI & in_last);
        push     = out_valid_q & (~full | (allow_push_when_full_with_pop & pop));
        in_ready = ~out_valid_q | push | ~closes;
        accept   = in_valid & in_ready;
        complete = accept & closes;
    end

    // Slices below idx come from the accumulator, the current beat lands at idx,
    // everything above stays zero.
    always_comb begin
        word = '0;
        for (int i = 0; i < ACC_N; i++) begin
            if (MULTI && (i < int'(idx_q))) begin
                word[i*in_width +: in_width] = acc_q[i];
            end
        end
        word[int'(idx_q)*in_width +: in_width] = in_data;
    end

    always_comb begin
        acc_d        = acc_q;
        idx_d        = idx_q;
        write_data_d = write_data_q;
        out_valid_d  = out_valid_q;
        if (push) begin
            out_valid_d = 1'b0;
        end
        if (complete) begin
            write_data_d = word;
            out_valid_d  = 1'b1;
            idx_d        = '0;
            acc_d        = '0;
        end else if (accept) begin
            acc_d[idx_q] = in_data;
            idx_d        = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q        <= '0;
            idx_q        <= '0;
            write_data_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            write_data_q <= write_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign write_data = write_data_q;

endmodule

// File: tb/tb_stream_to_fifo_packer.sv
// Directed bench for stream_to_fifo_packer: default instance, an instance that may
// push while full with pop, and a ratio=1 instance.
module tb_stream_to_fifo_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        full;
    logic        pop;
    logic        push;
    logic [31:0] write_data;

    logic        a_in_ready;
    logic        a_push;
    logic [31:0] a_write_data;

    logic        r_valid;
    logic        r_ready;
    logic [7:0]  r_data;
    logic        r_last;
    logic        r_full;
    logic        r_pop;
    logic        r_push;
    logic [7:0]  r_write_data;

    int n_checks;
    int n_fail;

    stream_to_fifo_packer u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .full(full), .pop(pop),
        .push(push), .write_data(write_data)
    );

    stream_to_fifo_packer #(.allow_push_when_full_with_pop(1'b1)) u_allow (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .full(full), .pop(pop),
        .push(a_push), .write_data(a_write_data)
    );

    stream_to_fifo_packer #(.ratio(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_valid), .in_ready(r_ready),
        .in_data(r_data), .in_last(r_last), .full(r_full), .pop(r_pop),
        .push(r_push), .write_data(r_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge; outputs are sampled 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        full = 1'b0; pop = 1'b0;
        r_valid = 1'b0; r_data = 8'h00; r_last = 1'b0; r_full = 1'b0; r_pop = 1'b0;
        next_cycle();
        next_cycle();
        #2;
        n_checks++;
        if (push !== 1'b0 || in_ready !== 1'b1 || write_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: push=%b in_ready=%b wd=%h, want push=0 in_ready=1 wd=0", push, in_ready, write_data);
        end
        n_checks++;
        if (r_push !== 1'b0 || r_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_r1: push=%b in_ready=%b, want push=0 in_ready=1", r_push, r_ready);
        end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_pack_basic();
        logic [7:0] beats [4];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = beats[i];
            #2;
            n_checks++;
            if (in_ready !== 1'b1 || push !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_beat%0d: in_ready=%b push=%b, want in_ready=1 push=0", i, in_ready, push);
            end
            next_cycle();
        end
        in_valid = 1'b0;
        #2;
        n_checks++;
        if (push !== 1'b1 || write_data !== 32'h44332211 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_push: push=%b wd=%h in_ready=%b, want push=1 wd=44332211 in_ready=1", push, write_data, in_ready);
        end
        next_cycle();
        #2;
        n_checks++;
        if (push !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_single_push: push=%b, want 0", push);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
        next_cycle();
        in_data = 8'hBB; in_last = 1'b1;
        #2;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready: in_ready=%b, want 1", in_ready);
        end
        next_cycle();
        in_valid = 1'b0; in_last = 1'b0;
        #2;
        n_checks++;
        if (push !== 1'b1 || write_data !== 32'h0000BBAA) begin
            n_fail++;
            $display("FAIL flush_word: push=%b wd=%h, want push=1 wd=0000bbaa", push, write_data);
        end
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            next_cycle();
        end
        in_valid = 1'b0;
        #2;
        n_checks++;
        if (push !== 1'b1 || write_data !== 32'h04030201) begin
            n_fail++;
            $display("FAIL flush_next_word: push=%b wd=%h, want push=1 wd=04030201", push, write_data);
        end
        next_cycle();
    endtask

    task automatic test_full_backpressure();
        full = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            #2;
            n_checks++;
            if (in_ready !== 1'b1 || push !== 1'b0) begin
                n_fail++;
                $display("FAIL full_beat%0d: in_ready=%b push=%b, want in_ready=1 push=0", i, in_ready, push);
            end
            next_cycle();
        end
        in_data = 8'h08;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_checks++;
            if (in_ready !== 1'b0 || push !== 1'b0 || write_data !== 32'h04030201) begin
                n_fail++;
                $display("FAIL full_stall%0d: in_ready=%b push=%b wd=%h, want in_ready=0 push=0 wd=04030201", c, in_ready, push, write_data);
            end
            next_cycle();
        end
        full = 1'b0;
        #2;
        n_checks++;
        if (push !== 1'b1 || write_data !== 32'h04030201 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_release: push=%b wd=%h in_ready=%b, want push=1 wd=04030201 in_ready=1", push, write_data, in_ready);
        end
        next_cycle();
        in_valid = 1'b0;
        #2;
        n_checks++;
        if (push !== 1'b1 || write_data !== 32'h08070605) begin
            n_fail++;
            $display("FAIL full_second_word: push=%b wd=%h, want push=1 wd=08070605", push, write_data);
        end
        next_cycle();
        #2;
        n_checks++;
        if (push !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drained: push=%b, want 0", push);
        end
        next_cycle();
    endtask

    task automatic test_full_with_pop();
        full = 1'b1; pop = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h10 + i);
            next_cycle();
        end
        in_valid = 1'b0; pop = 1'b1;
        #2;
        n_checks++;
        if (push !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_noallow: push=%b, want 0", push);
        end
        n_checks++;
        if (a_push !== 1'b1 || a_write_data !== 32'h14131211) begin
            n_fail++;
            $display("FAIL pop_allow: push=%b wd=%h, want push=1 wd=14131211", a_push, a_write_data);
        end
        next_cycle();
        pop = 1'b0;
        #2;
        n_checks++;
        if (push !== 1'b0 || write_data !== 32'h14131211 || a_push !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_hold: push=%b wd=%h allow_push=%b, want push=0 wd=14131211 allow_push=0", push, write_data, a_push);
        end
        next_cycle();
        full = 1'b0;
        #2;
        n_checks++;
        if (push !== 1'b1 || write_data !== 32'h14131211) begin
            n_fail++;
            $display("FAIL pop_release: push=%b wd=%h, want push=1 wd=14131211", push, write_data);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_word();
        in_valid = 1'b1; in_data = 8'h11;
        next_cycle();
        in_data = 8'h22;
        next_cycle();
        in_valid = 1'b0; rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        #2;
        n_checks++;
        if (push !== 1'b0 || in_ready !== 1'b1 || write_data !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset: push=%b in_ready=%b wd=%h, want push=0 in_ready=1 wd=0", push, in_ready, write_data);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h55 + 8'h11 * i);
            #2;
            n_checks++;
            if (push !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_beat%0d: push=%b, want 0", i, push);
            end
            next_cycle();
        end
        in_valid = 1'b0;
        #2;
        n_checks++;
        if (push !== 1'b1 || write_data !== 32'h88776655) begin
            n_fail++;
            $display("FAIL midreset_word: push=%b wd=%h, want push=1 wd=88776655", push, write_data);
        end
        next_cycle();
        #2;
        n_checks++;
        if (push !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_single: push=%b, want 0", push);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back_ratio1();
        for (int i = 1; i <= 5; i++) begin
            r_valid = 1'b1; r_data = 8'(i); r_last = (i == 3);
            #2;
            n_checks++;
            if (r_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL r1_ready%0d: in_ready=%b, want 1", i, r_ready);
            end
            if (i > 1) begin
                n_checks++;
                if (r_push !== 1'b1 || r_write_data !== 8'(i - 1)) begin
                    n_fail++;
                    $display("FAIL r1_push%0d: push=%b wd=%h, want push=1 wd=%h", i, r_push, r_write_data, 8'(i - 1));
                end
            end
            next_cycle();
        end
        r_valid = 1'b0; r_last = 1'b0;
        #2;
        n_checks++;
        if (r_push !== 1'b1 || r_write_data !== 8'h05) begin
            n_fail++;
            $display("FAIL r1_last: push=%b wd=%h, want push=1 wd=05", r_push, r_write_data);
        end
        next_cycle();
        #2;
        n_checks++;
        if (r_push !== 1'b0) begin
            n_fail++;
            $display("FAIL r1_idle: push=%b, want 0", r_push);
        end
        next_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_pack_basic();
        test_flush();
        test_full_backpressure();
        test_full_with_pop();
        test_reset_mid_word();
        test_back_to_back_ratio1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_to_fifo_packer.md
Name: stream_to_fifo_packer

Overview:
Upstream neighbour of the FIFO. Accepts a narrow valid/ready stream and packs `ratio` consecutive beats into one wide word. It pushes that word into the FIFO write port (push/write_data) and honours the FIFO's full flag. An optional early flush (in_last) emits a partially filled, zero-padded word. The block holds one completed wide word, so input beats keep flowing while the FIFO is briefly full.

Parameters:
in_width, 8, width of one input beat
ratio, 4, input beats per FIFO word; legal range 1..16
allow_push_when_full_with_pop, 0, when 1, push may be asserted while full is high if pop is high in the same cycle

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  synchronous reset, active low
in_valid  input  1  input beat valid
in_ready  output  1  block accepts the beat this cycle
in_data  input  in_width  input beat payload
in_last  input  1  flush: the beat with in_last closes the current word early
full  input  1  FIFO full flag
pop  input  1  FIFO pop in this cycle (used only if allow_push_when_full_with_pop)
push  output  1  FIFO write strobe
write_data  output  in_width*ratio  FIFO write payload

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n); it is sampled only on posedge clk.
- State:
  - accumulator of ratio-1 slices
  - beat index idx, width $clog2(ratio) (minimum 1 bit)
  - output holding register write_data with flag out_valid
- Reset, taking priority over everything: idx=0, accumulator=0, out_valid=0, write_data=0. Outputs: push=0, in_ready=1.
- accept = in_valid & in_ready.
- completing beat = accepted beat with idx==ratio-1 or in_last=1.
- push = out_valid & (~full | (allow_push_when_full_with_pop & pop)). Combinational from registered out_valid plus full/pop.
- in_ready:
  - 1 when the beat does not complete a word (accumulator always has space).
  - For a completing beat: 1 only if ~out_valid | push.
  - Implementation: in_ready = ~out_valid | push | (idx!=ratio-1 & ~in_last). Using in_last and in_valid in this path is allowed.
- Non-completing accept: accumulator slice idx <= in_data; idx <= idx+1.
- Completing accept:
  - write_data <= {in_data, accumulator slices idx-1..0}, beat 0 in bits [in_width-1:0].
  - All slices above idx are zero.
  - out_valid <= 1; idx <= 0; accumulator cleared to 0.
- Push without a completing accept the same cycle: out_valid <= 0. Push plus a completing accept the same cycle: new word replaces it, out_valid stays 1.
- Latency: push is asserted the cycle after the completing beat is accepted, provided full=0.
- write_data is held stable while out_valid=1 and push=0.
- ratio=1: every accepted beat completes a word; in_last is ignored. Full throughput is 1 word per cycle while full=0.
- in_last on beat idx 0 yields a word holding only that beat.
- in_valid=0 never changes idx or the accumulator.
- Reset mid-word discards the partial word and any held word; no push occurs during or after reset for discarded data.
- Invariants the verification engineer checks:
  - no push while full & ~(pop & allow_push_when_full_with_pop)
  - no accepted beat is lost or duplicated
  - beat order is preserved within and across words

Test Plan:
- Defaults, full=0. Beats 11,22,33,44 on consecutive cycles -> push=1 exactly one cycle after beat 44 accepted, write_data=32'h44332211; in_ready stays 1 throughout.
- Beats AA, BB with in_last=1 on BB -> push next cycle, write_data=32'h0000BBAA, idx back to 0. Next beats 01..04 -> write_data=32'h04030201.
- full=1 held; send 8 beats 01..08:
  - word 32'h04030201 is held; beats 05,06,07 are accepted
  - in_ready=0 on beat 08 and push=0 while full=1
  - drop full -> push with 32'h04030201; beat 08 accepted the same cycle; next cycle push with 32'h08070605
- Word held, full=1, pop=1: with allow_push_when_full_with_pop=1 -> push=1; with allow=0 -> push=0 until full=0.
- Beats 11,22 accepted, then rst_n=0 for 1 cycle -> push=0, in_ready=1. Beats 55,66,77,88 -> single push with 32'h88776655 (no 11/22 residue).
- ratio=1, full=0, beats 01..05 back-to-back -> push high 5 consecutive cycles, write_data 01..05 in order, in_ready never 0.
